fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Receiving end of the fetch-register handshake: accepts 3-wide fetch bundles
//   (PCs + instruction words + lane mask) qualified by valid_in.
//   Buffers bundles in a circular FIFO and back-pressures the fetch register via stall_ifr.
//   Presents the oldest bundle to decode through a valid/ready port; flush empties it in one cycle.
// PARAMETERS
//   WIDTH   3    lanes per bundle
//   DEPTH   8    bundle entries; must be a power of 2, >= 2
//   XLEN    32   width of PC and instruction words
// PORTS
//   clk          in   1             clock, rising edge
//   rst          in   1             reset, asynchronous, active-low
//   flush        in   1             discard all buffered bundles (branch/exception redirect)
//   valid_in     in   1             bundle on pc_in/inst_in/mask_in is valid (from fetch register)
//   pc_in        in   XLEN x WIDTH  lane PCs, lane 0 = oldest
//   inst_in      in   XLEN x WIDTH  lane instruction words, aligned with pc_in
//   mask_in      in   WIDTH         per-lane valid mask
//   stall_ifr    out  1             queue full; fetch register must hold its bundle
//   dec_valid    out  1             head bundle available to decode
//   dec_ready    in   1             decode accepts head bundle this cycle
//   dec_pc       out  XLEN x WIDTH  head bundle PCs
//   dec_inst     out  XLEN x WIDTH  head bundle instruction words
//   dec_mask     out  WIDTH         head bundle lane mask
//   occupancy    out  clog2(DEPTH)+1  current number of stored bundles
// BEHAVIOUR
//   Reset: rst low clears head/tail pointers and count immediately.
//     All outputs 0: stall_ifr=0, dec_valid=0, dec_pc/dec_inst/dec_mask=0, occupancy=0.
//   Handshakes:
//     enq = valid_in & ~stall_ifr & (|mask_in)
//     deq = dec_valid & dec_ready
//   A bundle with valid_in=1, stall_ifr=0, mask_in=0 is consumed and dropped (never stored).
//   While stall_ifr=1, a held bundle with valid_in=1 is NOT enqueued.
//     It is enqueued exactly once, on the first edge with stall_ifr=0.
//   stall_ifr = (count == DEPTH); a function of registered state only, no combinational path from inputs.
//   dec_valid = (count != 0).
//     dec_* show the entry at head; forced to 0 when empty.
//   Latency: no bypass. A bundle enqueued at edge N is visible on dec_* after edge N (1 cycle).
//   Pointers: tail advances on enq, head advances on deq; both wrap DEPTH-1 -> 0 (clog2(DEPTH) bits).
//   count (clog2(DEPTH)+1 bits):
//     +1 on enq only
//     -1 on deq only
//     unchanged on enq & deq, or on neither
//   Full: stall_ifr=1, no enq. A deq that edge makes count=DEPTH-1, so stall_ifr drops the next cycle.
//   Empty: dec_valid=0, dec_ready ignored, count never underflows.
//   Simultaneous enq & deq with 0 < count < DEPTH: both take effect; count unchanged.
//   Flush priority: flush=1 at an edge resets head=tail=count=0.
//     Any enq/deq that cycle is ignored.
//     dec_valid=0 and stall_ifr=0 from the next cycle.
//   Entry storage needs no reset; stored data is visible only through valid entries.
//   Reset asserted mid-operation discards all contents, identical to power-on reset.
// TESTING
//   1. Reset: rst=0 with valid_in=1 -> all outputs 0.
//      Release rst, enq PC {0x1C008,0x1C004,0x1C000} mask 3'b111
//      -> dec_valid=1 next cycle with the same PCs, occupancy=1.
//   2. Fill: dec_ready=0, 8 enqs -> stall_ifr=1 after the 8th.
//      Hold valid_in=1 for 3 cycles -> occupancy stays 8.
//      Pulse dec_ready 1 cycle -> stall_ifr=0 next cycle.
//      Held bundle enqueued once -> occupancy back to 8.
//   3. Streaming: valid_in=1, dec_ready=1 every cycle for 20 bundles
//      -> occupancy stays 1, PCs emerge in order with 1-cycle latency, no drops or duplicates.
//   4. Flush: occupancy=5, assert flush together with enq and deq
//      -> next cycle occupancy=0, dec_valid=0, stall_ifr=0; the flushed-cycle enq is absent.
//   5. Wrap/mask: 13 enq/deq pairs wrapping the pointers, including one bundle with mask_in=3'b000
//      -> zero-mask bundle never appears on dec_*; dec_mask matches mask_in per bundle.
//   6. Async reset mid-run: rst low between edges at occupancy=6
//      -> outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Receiving end of the fetch-register handshake. Accepts WIDTH-lane fetch
//   bundles (PCs, instruction words, lane mask) qualified by valid_in. Bundles
//   are stored in a DEPTH-entry circular FIFO. The oldest bundle is presented
//   to decode through a valid/ready port. flush empties the queue in one cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (clears pointers and count)
//   flush      in   discard every buffered bundle (redirect)
//   valid_in   in   bundle on pc_in/inst_in/mask_in is valid
//   pc_in      in   lane PCs, lane 0 = oldest
//   inst_in    in   lane instruction words, aligned with pc_in
//   mask_in    in   per-lane valid mask; an all-zero mask is dropped
//   stall_ifr  out  queue full, fetch register must hold its bundle
//   dec_valid  out  head bundle available to decode
//   dec_ready  in   decode takes the head bundle this cycle
//   dec_pc     out  head bundle PCs (0 when empty)
//   dec_inst   out  head bundle instruction words (0 when empty)
//   dec_mask   out  head bundle lane mask (0 when empty)
//   occupancy  out  number of stored bundles
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             valid_in,
  input  logic [WIDTH-1:0][XLEN-1:0]       pc_in,
  input  logic [WIDTH-1:0][XLEN-1:0]       inst_in,
  input  logic [WIDTH-1:0]                 mask_in,
  output logic                             stall_ifr,
  output logic                             dec_valid,
  input  logic                             dec_ready,
  output logic [WIDTH-1:0][XLEN-1:0]       dec_pc,
  output logic [WIDTH-1:0][XLEN-1:0]       dec_inst,
  output logic [WIDTH-1:0]                 dec_mask,
  output logic [$clog2(DEPTH):0]           occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage; deliberately not reset, only reachable through valid entries.
  logic [WIDTH-1:0][XLEN-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0][XLEN-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0]           mask_mem [DEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Full/empty derive from the registered count only, so stall_ifr and
  // dec_valid have no combinational path from any input.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A zero-mask bundle is accepted from the fetch register but never stored.
  assign enq = valid_in & ~full & (|mask_in);
  assign deq = ~empty & dec_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Redirect wins over any handshake in the same cycle.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps DEPTH-1 -> 0.
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      if (enq && !deq) count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      pc_mem[tail_q]   <= pc_in;
      inst_mem[tail_q] <= inst_in;
      mask_mem[tail_q] <= mask_in;
    end
  end

  assign stall_ifr = full;
  assign dec_valid = ~empty;
  assign occupancy = count_q;

  // Head entry is gated to zero when empty so stale storage never leaks out.
  assign dec_pc   = empty ? '0 : pc_mem[head_q];
  assign dec_inst = empty ? '0 : inst_mem[head_q];
  assign dec_mask = empty ? '0 : mask_mem[head_q];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               valid_in;
  logic [2:0][31:0]   pc_in;
  logic [2:0][31:0]   inst_in;
  logic [2:0]         mask_in;
  logic               stall_ifr;
  logic               dec_valid;
  logic               dec_ready;
  logic [2:0][31:0]   dec_pc;
  logic [2:0][31:0]   dec_inst;
  logic [2:0]         dec_mask;
  logic [3:0]         occupancy;

  int checks;
  int failures;

  fetch_queue #(.WIDTH(3), .DEPTH(8), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .mask_in   (mask_in),
    .stall_ifr (stall_ifr),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_pc    (dec_pc),
    .dec_inst  (dec_inst),
    .dec_mask  (dec_mask),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 holds the oldest PC; lanes step by 4 bytes.
  function automatic logic [2:0][31:0] mk_pc(input logic [31:0] base);
    logic [2:0][31:0] b;
    b[0] = base;
    b[1] = base + 32'd4;
    b[2] = base + 32'd8;
    return b;
  endfunction

  function automatic logic [2:0][31:0] mk_inst(input logic [31:0] base);
    logic [2:0][31:0] b;
    b[0] = base ^ 32'hA5A5_0013;
    b[1] = (base + 32'd4) ^ 32'hA5A5_0013;
    b[2] = (base + 32'd8) ^ 32'hA5A5_0013;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] base, input logic [2:0] m, input logic rdy);
    valid_in  = v;
    pc_in     = mk_pc(base);
    inst_in   = mk_inst(base);
    mask_in   = m;
    dec_ready = rdy;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    dec_ready = 1'b0;
    flush     = 1'b0;
    mask_in   = 3'b000;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h0001_C000, 3'b111, 1'b1);
    #12;
    checks++; if (stall_ifr !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_ifr); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
    checks++; if (dec_pc !== 96'd0) begin failures++; $display("FAIL reset_dec_pc got=%h exp=0", dec_pc); end
    checks++; if (dec_inst !== 96'd0) begin failures++; $display("FAIL reset_dec_inst got=%h exp=0", dec_inst); end
    checks++; if (dec_mask !== 3'b000) begin failures++; $display("FAIL reset_dec_mask got=%b exp=0", dec_mask); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    // Release away from the clock edge, then enqueue the first bundle.
    step();
    rst = 1'b1;
    drive(1'b1, 32'h0001_C000, 3'b111, 1'b0);
    step();
    idle();
    $display("reset: enq pc0=%h", 32'h0001_C000);
    checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL first_dec_valid got=%b exp=1", dec_valid); end
    checks++; if (dec_pc !== mk_pc(32'h0001_C000)) begin failures++; $display("FAIL first_dec_pc got=%h exp=%h", dec_pc, mk_pc(32'h0001_C000)); end
    checks++; if (dec_inst !== mk_inst(32'h0001_C000)) begin failures++; $display("FAIL first_dec_inst got=%h exp=%h", dec_inst, mk_inst(32'h0001_C000)); end
    checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL first_occ got=%0d exp=1", occupancy); end
    do_flush();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i) * 32'h10, 3'b111, 1'b0);
      step();
      $display("fill: enq %0d pc0=%h occ=%0d", i, 32'h0000_2000 + 32'(i) * 32'h10, occupancy);
      if (i == 6) begin
        checks++; if (stall_ifr !== 1'b0) begin failures++; $display("FAIL fill_stall_at7 got=%b exp=0", stall_ifr); end
      end
    end
    checks++; if (stall_ifr !== 1'b1) begin failures++; $display("FAIL fill_stall_full got=%b exp=1", stall_ifr); end
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_occ_full got=%0d exp=8", occupancy); end
    // Held bundle while stalled must not be taken.
    drive(1'b1, 32'h0000_3000, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL hold_occ[%0d] got=%0d exp=8", i, occupancy); end
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    checks++; if (stall_ifr !== 1'b0) begin failures++; $display("FAIL pop_stall got=%b exp=0", stall_ifr); end
    checks++; if (occupancy !== 4'd7) begin failures++; $display("FAIL pop_occ got=%0d exp=7", occupancy); end
    step();
    valid_in = 1'b0;
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL held_enq_occ got=%0d exp=8", occupancy); end
    step();
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL held_once_occ got=%0d exp=8", occupancy); end
    // Drain: 0x2010..0x2070 then the held 0x3000 exactly once.
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_base;
      exp_base = (i < 7) ? 32'h0000_2010 + 32'(i) * 32'h10 : 32'h0000_3000;
      checks++; if (dec_pc !== mk_pc(exp_base)) begin failures++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, dec_pc, mk_pc(exp_base)); end
      step();
    end
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", dec_valid); end
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] b;
      b = 32'h0000_4000 + 32'(i) * 32'h20;
      drive(1'b1, b, 3'b111, 1'b1);
      step();
      $display("stream: bundle %0d pc0=%h occ=%0d", i, dec_pc[0], occupancy);
      checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
      checks++; if (dec_pc !== mk_pc(b)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, dec_pc, mk_pc(b)); end
    end
    valid_in = 1'b0;
    step();
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", dec_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_5000 + 32'(i) * 32'h10, 3'b111, 1'b0);
      step();
    end
    checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=5", occupancy); end
    drive(1'b1, 32'h0000_5F00, 3'b111, 1'b1);
    flush = 1'b1;
    step();
    idle();
    $display("flush: asserted with enq+deq, occ=%0d", occupancy);
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", dec_valid); end
    checks++; if (stall_ifr !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_ifr); end
    checks++; if (dec_pc !== 96'd0) begin failures++; $display("FAIL flush_pc got=%h exp=0", dec_pc); end
    step();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_enq_absent got=%0d exp=0", occupancy); end
    drive(1'b1, 32'h0000_5100, 3'b011, 1'b0);
    step();
    idle();
    checks++; if (dec_pc !== mk_pc(32'h0000_5100)) begin failures++; $display("FAIL post_flush_pc got=%h exp=%h", dec_pc, mk_pc(32'h0000_5100)); end
    checks++; if (dec_mask !== 3'b011) begin failures++; $display("FAIL post_flush_mask got=%b exp=011", dec_mask); end
    do_flush();
  endtask

  task automatic test_wrap_mask();
    logic [2:0] masks [13];
    masks = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111,
              3'b000, 3'b001, 3'b111, 3'b010, 3'b100, 3'b011};
    for (int i = 0; i < 13; i++) begin
      logic [31:0] b;
      b = 32'h0000_6000 + 32'(i) * 32'h10;
      drive(1'b1, b, masks[i], 1'b0);
      step();
      valid_in = 1'b0;
      $display("wrap: bundle %0d mask=%b occ=%0d", i, masks[i], occupancy);
      if (masks[i] == 3'b000) begin
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL zero_mask_valid[%0d] got=%b exp=0", i, dec_valid); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL zero_mask_occ[%0d] got=%0d exp=0", i, occupancy); end
      end else begin
        checks++; if (dec_pc !== mk_pc(b)) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, dec_pc, mk_pc(b)); end
        checks++; if (dec_mask !== masks[i]) begin failures++; $display("FAIL wrap_mask[%0d] got=%b exp=%b", i, dec_mask, masks[i]); end
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL wrap_occ[%0d] got=%0d exp=1", i, occupancy); end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL wrap_deq_occ[%0d] got=%0d exp=0", i, occupancy); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h0000_7000 + 32'(i) * 32'h10, 3'b111, 1'b0);
      step();
    end
    checks++; if (occupancy !== 4'd6) begin failures++; $display("FAIL areset_pre_occ got=%0d exp=6", occupancy); end
    // Assert reset between edges and sample before the next rising edge.
    #3;
    rst = 1'b0;
    #1;
    $display("async reset: asserted mid-cycle, occ=%0d", occupancy);
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", dec_valid); end
    checks++; if (stall_ifr !== 1'b0) begin failures++; $display("FAIL areset_stall got=%b exp=0", stall_ifr); end
    checks++; if (dec_pc !== 96'd0) begin failures++; $display("FAIL areset_pc got=%h exp=0", dec_pc); end
    checks++; if (dec_mask !== 3'b000) begin failures++; $display("FAIL areset_mask got=%b exp=0", dec_mask); end
    step();
    rst = 1'b1;
    idle();
    step();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL areset_after_occ got=%0d exp=0", occupancy); end
    drive(1'b1, 32'h0000_7800, 3'b101, 1'b0);
    step();
    idle();
    checks++; if (dec_pc !== mk_pc(32'h0000_7800)) begin failures++; $display("FAIL areset_new_pc got=%h exp=%h", dec_pc, mk_pc(32'h0000_7800)); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    dec_ready = 1'b0;
    pc_in    = '0;
    inst_in  = '0;
    mask_in  = '0;
    test_reset();
    test_fill();
    test_streaming();
    test_flush();
    test_wrap_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
